// File: rtl/ata_pio_tctrl_if.sv
// Host/ATA signal bundle for the OCIDEC-1 PIO timing controller.
// master: host-side driver (bus interface or bench); slave: the controller.
interface ata_pio_tctrl_if #(
  parameter int unsigned TWIDTH = 8
);
  logic              go;
  logic              we;
  logic [TWIDTH-1:0] T1;
  logic [TWIDTH-1:0] T2;
  logic [TWIDTH-1:0] Teoc;
  logic              IORDYen;
  logic              IORDY;
  logic [15:0]       wdata;
  logic [15:0]       DDi;
  logic [15:0]       DDo;
  logic              DDoe;
  logic              DIOR;
  logic              DIOW;
  logic [15:0]       rdata;
  logic              busy;
  logic              done;

  modport master (
    output go, we, T1, T2, Teoc, IORDYen, IORDY, wdata, DDi,
    input  DDo, DDoe, DIOR, DIOW, rdata, busy, done
  );

  modport slave (
    input  go, we, T1, T2, Teoc, IORDYen, IORDY, wdata, DDi,
    output DDo, DDoe, DIOR, DIOW, rdata, busy, done
  );
endinterface

// File: rtl/ata_pio_tctrl.sv
// ATA PIO transfer timing controller (OCIDEC-1, host side).
// One access per go: address setup (T1), strobe (T2, IORDY-extendable),
// end-of-cycle recovery (Teoc), then a one-cycle done pulse.
module ata_pio_tctrl #(
  parameter int unsigned TWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 rst,
  ata_pio_tctrl_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOV} state_t;

  state_t            state_q, state_nxt;
  logic [TWIDTH-1:0] cnt_q, cnt_d;
  logic [TWIDTH-1:0] t2_q, t2_d, teoc_q, teoc_d;
  logic              we_q, we_d, iordyen_q, iordyen_d;
  logic [15:0]       ddo_q, ddo_d, rdata_q, rdata_d;
  logic              ddoe_q, ddoe_d, dior_q, dior_d, diow_q, diow_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              iordy_m, iordy_s;
  logic              cnt_zero, advance;

  assign cnt_zero = (cnt_q == '0);
  assign advance  = (state_nxt != state_q);

  // Two-flop synchroniser for the asynchronous device IORDY line.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      iordy_m <= 1'b0;
      iordy_s <= 1'b0;
    end else if (rst) begin
      iordy_m <= 1'b0;
      iordy_s <= 1'b0;
    end else begin
      iordy_m <= bus.IORDY;
      iordy_s <= iordy_m;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)  state_q <= IDLE;
    else if (rst) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  // Next-state: each phase ends when its counter reaches zero; strobe also waits on IORDY.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (bus.go) state_nxt = SETUP;
      SETUP:   if (cnt_zero) state_nxt = STROBE;
      STROBE:  if (cnt_zero && (!iordyen_q || iordy_s)) state_nxt = RECOV;
      RECOV:   if (cnt_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values; the registered outputs only change on phase transitions.
  always_comb begin
    cnt_d     = cnt_zero ? cnt_q : cnt_q - TWIDTH'(1);
    t2_d      = t2_q;
    teoc_d    = teoc_q;
    we_d      = we_q;
    iordyen_d = iordyen_q;
    ddo_d     = ddo_q;
    rdata_d   = rdata_q;
    ddoe_d    = ddoe_q;
    dior_d    = dior_q;
    diow_d    = diow_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (advance) begin
      case (state_q)
        IDLE: begin
          cnt_d     = bus.T1;
          t2_d      = bus.T2;
          teoc_d    = bus.Teoc;
          we_d      = bus.we;
          iordyen_d = bus.IORDYen;
          ddo_d     = bus.wdata;
          ddoe_d    = bus.we;
          busy_d    = 1'b1;
        end
        SETUP: begin
          cnt_d  = t2_q;
          diow_d = we_q;
          dior_d = ~we_q;
        end
        STROBE: begin
          cnt_d  = teoc_q;
          dior_d = 1'b0;
          diow_d = 1'b0;
          if (!we_q) rdata_d = bus.DDi;
        end
        RECOV: begin
          busy_d = 1'b0;
          ddoe_d = 1'b0;
          done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath/output registers; sync rst aborts an access with strobes dropped at once.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset || rst) begin
      cnt_q     <= '0;
      t2_q      <= '0;
      teoc_q    <= '0;
      we_q      <= 1'b0;
      iordyen_q <= 1'b0;
      ddo_q     <= '0;
      rdata_q   <= '0;
      ddoe_q    <= 1'b0;
      dior_q    <= 1'b0;
      diow_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      t2_q      <= t2_d;
      teoc_q    <= teoc_d;
      we_q      <= we_d;
      iordyen_q <= iordyen_d;
      ddo_q     <= ddo_d;
      rdata_q   <= rdata_d;
      ddoe_q    <= ddoe_d;
      dior_q    <= dior_d;
      diow_q    <= diow_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.DDo   = ddo_q;
  assign bus.DDoe  = ddoe_q;
  assign bus.DIOR  = dior_q;
  assign bus.DIOW  = diow_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_ata_pio_tctrl.sv
// Directed bench for ata_pio_tctrl: edge-numbered timing checks, edge 0 = edge sampling go.
module tb_ata_pio_tctrl;

  logic clk;
  logic nReset;
  logic rst;
  int   checks;
  int   failures;

  ata_pio_tctrl_if #(.TWIDTH(8)) bus ();

  ata_pio_tctrl #(.TWIDTH(8)) dut (
    .clk    (clk),
    .nReset (nReset),
    .rst    (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; inputs change and outputs are sampled 1 ns after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setup_access(input logic w, input logic [7:0] t1, input logic [7:0] t2,
                              input logic [7:0] te, input logic ien);
    bus.we      = w;
    bus.T1      = t1;
    bus.T2      = t2;
    bus.Teoc    = te;
    bus.IORDYen = ien;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    nReset      = 1'b0;
    rst         = 1'b0;
    bus.go      = 1'b0;
    bus.IORDY   = 1'b1;
    bus.wdata   = 16'h0000;
    bus.DDi     = 16'h0000;
    setup_access(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);

    // Reset state
    #12;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_dior", {31'b0, bus.DIOR}, 32'd0);
    chk("rst_ddoe", {31'b0, bus.DDoe}, 32'd0);
    nReset = 1'b1;
    step(2);

    // 1: read T1=2 T2=4 Teoc=3
    setup_access(1'b0, 8'd2, 8'd4, 8'd3, 1'b0);
    bus.DDi = 16'hA5C3;
    bus.go  = 1'b1;
    step(1);
    bus.go = 1'b0;
    chk("t1_busy_e0", {31'b0, bus.busy}, 32'd1);
    chk("t1_dior_e0", {31'b0, bus.DIOR}, 32'd0);
    step(2);
    chk("t1_dior_e2", {31'b0, bus.DIOR}, 32'd0);
    step(1);
    chk("t1_dior_e3", {31'b0, bus.DIOR}, 32'd1);
    chk("t1_diow_e3", {31'b0, bus.DIOW}, 32'd0);
    chk("t1_ddoe_e3", {31'b0, bus.DDoe}, 32'd0);
    step(4);
    chk("t1_dior_e7", {31'b0, bus.DIOR}, 32'd1);
    step(1);
    chk("t1_dior_e8", {31'b0, bus.DIOR}, 32'd0);
    chk("t1_rdata_e8", {16'b0, bus.rdata}, 32'h0000A5C3);
    bus.DDi = 16'h0000;
    step(3);
    chk("t1_done_e11", {31'b0, bus.done}, 32'd0);
    chk("t1_busy_e11", {31'b0, bus.busy}, 32'd1);
    step(1);
    chk("t1_done_e12", {31'b0, bus.done}, 32'd1);
    chk("t1_busy_e12", {31'b0, bus.busy}, 32'd0);
    chk("t1_rdata_e12", {16'b0, bus.rdata}, 32'h0000A5C3);
    step(1);
    chk("t1_done_e13", {31'b0, bus.done}, 32'd0);

    // 2: write T1=1 T2=2 Teoc=1 -> strobe edges 2..5, done at edge 7
    setup_access(1'b1, 8'd1, 8'd2, 8'd1, 1'b0);
    bus.wdata = 16'h1234;
    bus.go    = 1'b1;
    step(1);
    bus.go    = 1'b0;
    bus.wdata = 16'hFFFF;
    chk("t2_ddoe_e0", {31'b0, bus.DDoe}, 32'd1);
    chk("t2_ddo_e0", {16'b0, bus.DDo}, 32'h00001234);
    chk("t2_diow_e0", {31'b0, bus.DIOW}, 32'd0);
    step(1);
    chk("t2_diow_e1", {31'b0, bus.DIOW}, 32'd0);
    step(1);
    chk("t2_diow_e2", {31'b0, bus.DIOW}, 32'd1);
    chk("t2_dior_e2", {31'b0, bus.DIOR}, 32'd0);
    step(2);
    chk("t2_diow_e4", {31'b0, bus.DIOW}, 32'd1);
    step(1);
    chk("t2_diow_e5", {31'b0, bus.DIOW}, 32'd0);
    chk("t2_ddoe_e5", {31'b0, bus.DDoe}, 32'd1);
    step(1);
    chk("t2_done_e6", {31'b0, bus.done}, 32'd0);
    chk("t2_ddoe_e6", {31'b0, bus.DDoe}, 32'd1);
    chk("t2_ddo_e6", {16'b0, bus.DDo}, 32'h00001234);
    step(1);
    chk("t2_done_e7", {31'b0, bus.done}, 32'd1);
    chk("t2_ddoe_e7", {31'b0, bus.DDoe}, 32'd0);

    // 3: read T=0/0/0 with IORDY wait
    bus.IORDY = 1'b0;
    step(3);
    setup_access(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    bus.DDi = 16'h5A5A;
    bus.go  = 1'b1;
    step(1);
    bus.go = 1'b0;
    step(1);
    chk("t3_dior_e1", {31'b0, bus.DIOR}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t3_dior_wait", {31'b0, bus.DIOR}, 32'd1);
    end
    bus.IORDY = 1'b1;
    step(2);
    chk("t3_dior_sync", {31'b0, bus.DIOR}, 32'd1);
    step(1);
    chk("t3_dior_end", {31'b0, bus.DIOR}, 32'd0);
    chk("t3_rdata", {16'b0, bus.rdata}, 32'h00005A5A);
    chk("t3_done_early", {31'b0, bus.done}, 32'd0);
    step(1);
    chk("t3_done", {31'b0, bus.done}, 32'd1);

    // 4: go held high, T=0/0/0 -> done at edges 3, 7, 11
    setup_access(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    bus.go = 1'b1;
    step(1);
    chk("t4_busy_e0", {31'b0, bus.busy}, 32'd1);
    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk("t4_done", {31'b0, bus.done}, {31'b0, (i % 4) == 3});
      chk("t4_busy", {31'b0, bus.busy}, {31'b0, (i % 4) != 3});
    end
    bus.go = 1'b0;
    step(4);
    chk("t4_busy_drain", {31'b0, bus.busy}, 32'd0);

    // 5: sync rst mid-STROBE of a write, then a fresh read
    setup_access(1'b1, 8'd0, 8'd5, 8'd2, 1'b0);
    bus.wdata = 16'hBEEF;
    bus.go    = 1'b1;
    step(1);
    bus.go = 1'b0;
    step(3);
    chk("t5_diow_mid", {31'b0, bus.DIOW}, 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_diow", {31'b0, bus.DIOW}, 32'd0);
    chk("t5_ddoe", {31'b0, bus.DDoe}, 32'd0);
    chk("t5_busy", {31'b0, bus.busy}, 32'd0);
    chk("t5_done", {31'b0, bus.done}, 32'd0);
    chk("t5_ddo", {16'b0, bus.DDo}, 32'h00000000);
    step(1);
    chk("t5_no_recov", {31'b0, bus.busy}, 32'd0);
    setup_access(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    bus.DDi = 16'h0F0F;
    bus.go  = 1'b1;
    step(1);
    bus.go = 1'b0;
    chk("t5_new_busy", {31'b0, bus.busy}, 32'd1);
    step(3);
    chk("t5_new_done", {31'b0, bus.done}, 32'd1);
    chk("t5_new_rdata", {16'b0, bus.rdata}, 32'h00000F0F);

    // 6: max timing read -> strobe edges 256..512, done at edge 768
    setup_access(1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    bus.DDi = 16'hC0DE;
    bus.go  = 1'b1;
    step(1);
    bus.go = 1'b0;
    step(255);
    chk("t6_dior_e255", {31'b0, bus.DIOR}, 32'd0);
    step(1);
    chk("t6_dior_e256", {31'b0, bus.DIOR}, 32'd1);
    step(255);
    chk("t6_dior_e511", {31'b0, bus.DIOR}, 32'd1);
    step(1);
    chk("t6_dior_e512", {31'b0, bus.DIOR}, 32'd0);
    chk("t6_rdata", {16'b0, bus.rdata}, 32'h0000C0DE);
    step(255);
    chk("t6_done_e767", {31'b0, bus.done}, 32'd0);
    step(1);
    chk("t6_done_e768", {31'b0, bus.done}, 32'd1);

    // 6b: async nReset mid-SETUP of a max-timing write
    setup_access(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    bus.wdata = 16'h7777;
    bus.go    = 1'b1;
    step(1);
    bus.go = 1'b0;
    step(10);
    chk("t6b_ddoe_pre", {31'b0, bus.DDoe}, 32'd1);
    chk("t6b_busy_pre", {31'b0, bus.busy}, 32'd1);
    #2;
    nReset = 1'b0;
    #1;
    chk("t6b_busy", {31'b0, bus.busy}, 32'd0);
    chk("t6b_ddoe", {31'b0, bus.DDoe}, 32'd0);
    chk("t6b_ddo", {16'b0, bus.DDo}, 32'h00000000);
    chk("t6b_rdata", {16'b0, bus.rdata}, 32'h00000000);
    chk("t6b_dior", {31'b0, bus.DIOR}, 32'd0);
    chk("t6b_done", {31'b0, bus.done}, 32'd0);
    #1;
    nReset = 1'b1;
    step(2);
    chk("t6b_idle", {31'b0, bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
